cpu_step_ctrl: RTL and testbench



---
 rtl/cpu_step_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Debounced step button driving a one-cycle CPU clock-enable, with single-step,
// N-step burst and divided-rate free-run modes plus a PC breakpoint halt.
module cpu_step_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int DEB_W      = 20,
    parameter int RATE       = 3,
    parameter int RATE_W     = 24,
    parameter int PC_W       = 32,
    parameter int BURST_W    = 8,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn,
    input  logic [1:0]         mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [PC_W-1:0]    pc,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic               bp_en,
    output logic               cpu_ce,
    output logic               running,
    output logic               bp_hit,
    output logic [CNT_W-1:0]   step_count
);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RATE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state;
    logic               sync_q1;
    logic               sync_q2;
    logic               deb_level;
    logic [DEB_W-1:0]   deb_cnt;
    logic [RATE_W-1:0]  rate_cnt;
    logic [BURST_W-1:0] remaining;
    logic               first;
    logic               press;
    logic               tick;
    logic               bp_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // The stable level only moves after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (sync_q2 == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_level <= sync_q2;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Press is flagged in the cycle the stable level is about to rise.
    assign press    = sync_q2 && !deb_level && (deb_cnt == DEB_LAST);
    assign tick     = (rate_cnt == RATE_LAST);
    assign bp_match = bp_en && (pc == bp_addr) && !first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cpu_ce     <= 1'b0;
            running    <= 1'b0;
            bp_hit     <= 1'b0;
            step_count <= '0;
            rate_cnt   <= '0;
            remaining  <= '0;
            first      <= 1'b0;
        end else begin
            cpu_ce <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        bp_hit <= 1'b0;
                        case (mode)
                            2'b01: begin
                                remaining <= burst_len;
                                if (burst_len != '0) begin
                                    state    <= BURST;
                                    running  <= 1'b1;
                                    rate_cnt <= '0;
                                    first    <= 1'b1;
                                end
                            end
                            2'b10: begin
                                state    <= RUN;
                                running  <= 1'b1;
                                rate_cnt <= '0;
                                first    <= 1'b1;
                            end
                            default: begin
                                cpu_ce     <= 1'b1;
                                step_count <= step_count + 1'b1;
                            end
                        endcase
                    end
                end
                BURST, RUN: begin
                    // A press stops RUN outright, swallowing any coincident tick.
                    if (state == RUN && press) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (tick) begin
                        rate_cnt <= '0;
                        if (bp_match) begin
                            state   <= IDLE;
                            running <= 1'b0;
                            bp_hit  <= 1'b1;
                        end else begin
                            cpu_ce     <= 1'b1;
                            step_count <= step_count + 1'b1;
                            first      <= 1'b0;
                            if (state == BURST) begin
                                remaining <= remaining - 1'b1;
                                if (remaining == BURST_W'(1)) begin
                                    state   <= IDLE;
                                    running <= 1'b0;
                                end
                            end
                        end
                    end else begin
                        rate_cnt <= rate_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: table-driven step/burst scenarios,
// hand-written run/breakpoint/reset sequences and a pulse scoreboard.
module tb_cpu_step_ctrl;

    localparam int RATE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn;
    logic        btn4;
    logic [1:0]  mode;
    logic [7:0]  burst_len;
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_en;
    logic        cpu_ce;
    logic        running;
    logic        bp_hit;
    logic [15:0] step_count;
    logic        cpu_ce4;
    logic        running4;
    logic        bp_hit4;
    logic [3:0]  step_count4;
    logic        pc_clear;

    typedef struct {
        logic [15:0] cnt;
        logic [31:0] pc;
        bit          chk_pc;
        int          gap;
        logic        run;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] len;
        int         pulses;
        logic       run_mid;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_ce_cyc = 0;
    int          pulses4 = 0;
    int          mon_gap;
    exp_t        mon_e;
    logic [15:0] exp_cnt;

    cpu_step_ctrl u_dut (
        .clk(clk), .rst(rst), .btn(btn), .mode(mode), .burst_len(burst_len),
        .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .cpu_ce(cpu_ce),
        .running(running), .bp_hit(bp_hit), .step_count(step_count)
    );

    cpu_step_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .btn(btn4), .mode(2'b00), .burst_len(8'd0),
        .pc(32'd0), .bp_addr(32'd0), .bp_en(1'b0), .cpu_ce(cpu_ce4),
        .running(running4), .bp_hit(bp_hit4), .step_count(step_count4)
    );

    always #5 clk = ~clk;

    // Stand-in CPU: advances its PC by one instruction per enable.
    always @(posedge clk) begin
        if (pc_clear) pc <= 32'd0;
        else if (cpu_ce) pc <= pc + 32'd4;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (cpu_ce4 === 1'b1) pulses4++;
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every cpu_ce pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (cpu_ce === 1'b1) begin
            mon_gap = cyc - last_ce_cyc;
            last_ce_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: actual=pulse required=none (step_count=%0d)", step_count);
            end else begin
                mon_e = sb.pop_front();
                checkValue("pulse_step_count", 32'(step_count), 32'(mon_e.cnt));
                checkValue("pulse_running", 32'(running), 32'(mon_e.run));
                if (mon_e.chk_pc) checkValue("pulse_pc", pc, mon_e.pc);
                if (mon_e.gap != 0) checkValue("pulse_gap", 32'(mon_gap), 32'(mon_e.gap));
            end
        end
    end

    task automatic pushPulses(input int n, input bit last_idle, input bit chk_pc, input logic [31:0] pc0);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            exp_cnt  = exp_cnt + 16'd1;
            e.cnt    = exp_cnt;
            e.pc     = pc0 + 32'(4 * i);
            e.chk_pc = chk_pc;
            e.gap    = (i == 0) ? 0 : RATE;
            e.run    = !(last_idle && (i == n - 1));
            sb.push_back(e);
        end
    endtask

    task automatic pressStart();
        @(negedge clk) btn = 1'b1;
        repeat (8) @(negedge clk);
        btn = 1'b0;
    endtask

    task automatic waitPulses(input int k, input int bound);
        int seen = 0;
        int n = 0;
        while (seen < k && n < bound) begin
            @(negedge clk);
            n++;
            if (cpu_ce === 1'b1) seen++;
        end
        if (seen < k) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_pulses: actual=%0d required=%0d", seen, k);
        end
    endtask

    task automatic checkOutput(input logic exp_bp);
        checkValue("step_count", 32'(step_count), 32'(exp_cnt));
        checkValue("running_idle", 32'(running), 32'd0);
        checkValue("bp_hit", 32'(bp_hit), 32'(exp_bp));
        checkValue("missing_pulses", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic applyStimulus(input vec_t v);
        mode      = v.mode;
        burst_len = v.len;
        bp_en     = 1'b0;
        pushPulses(v.pulses, 1'b1, 1'b0, 32'd0);
        @(negedge clk) btn = 1'b1;
        repeat (8) @(negedge clk);
        checkValue("running_mid", 32'(running), 32'(v.run_mid));
        btn = 1'b0;
        repeat (v.pulses * RATE + 20) @(negedge clk);
    endtask

    // Second press lands exactly on the tick that would give pulse n+1.
    task automatic runStop(input int n);
        pressStart();
        waitPulses(n - 2, 60);
        repeat (3) @(negedge clk);
        btn = 1'b1;
        repeat (8) @(negedge clk);
        btn = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        exp_cnt = 16'd0;
        sb.delete();
    endtask

    initial begin
        int lat;
        rst = 1'b1; btn = 1'b0; btn4 = 1'b0; mode = 2'b00; burst_len = 8'd0;
        bp_addr = 32'd0; bp_en = 1'b0; pc_clear = 1'b1; exp_cnt = 16'd0;
        vecs[0] = '{2'b00, 8'd0, 1, 1'b0};
        vecs[1] = '{2'b11, 8'd7, 1, 1'b0};
        vecs[2] = '{2'b01, 8'd5, 5, 1'b1};
        vecs[3] = '{2'b01, 8'd0, 0, 1'b0};
        vecs[4] = '{2'b01, 8'd1, 1, 1'b1};
        vecs[5] = '{2'b01, 8'd3, 3, 1'b1};

        repeat (3) @(negedge clk);
        checkValue("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        checkValue("rst_running", 32'(running), 32'd0);
        checkValue("rst_bp_hit", 32'(bp_hit), 32'd0);
        checkValue("rst_step_count", 32'(step_count), 32'd0);
        @(negedge clk) rst = 1'b0; pc_clear = 1'b0;

        $display("[TB] step latency");
        mode = 2'b00;
        pushPulses(1, 1'b1, 1'b0, 32'd0);
        @(negedge clk) btn = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (cpu_ce === 1'b1 && lat == 0) lat = i;
        end
        @(negedge clk) btn = 1'b0;
        repeat (20) @(negedge clk);
        checkValue("step_latency", 32'(lat), 32'd6);
        checkOutput(1'b0);

        $display("[TB] glitch");
        @(negedge clk) btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput(1'b0);

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(1'b0);
        end

        $display("[TB] run stop on tick");
        doReset();
        mode = 2'b10;
        bp_en = 1'b0;
        pushPulses(7, 1'b0, 1'b0, 32'd0);
        runStop(7);
        checkOutput(1'b0);

        $display("[TB] breakpoint and resume");
        @(negedge clk) pc_clear = 1'b1;
        @(negedge clk) pc_clear = 1'b0;
        bp_en = 1'b1;
        bp_addr = 32'h10;
        pushPulses(4, 1'b0, 1'b1, 32'd0);
        pressStart();
        repeat (40) @(negedge clk);
        checkOutput(1'b1);
        pushPulses(5, 1'b0, 1'b1, 32'h10);
        runStop(5);
        checkOutput(1'b0);

        $display("[TB] reset mid-burst");
        bp_en = 1'b0;
        mode = 2'b01;
        burst_len = 8'd8;
        pushPulses(2, 1'b0, 1'b0, 32'd0);
        pressStart();
        waitPulses(2, 30);
        #2 rst = 1'b1;
        #1;
        checkValue("abort_cpu_ce", 32'(cpu_ce), 32'd0);
        checkValue("abort_running", 32'(running), 32'd0);
        checkValue("abort_step_count", 32'(step_count), 32'd0);
        @(negedge clk) rst = 1'b0;
        exp_cnt = 16'd0;
        repeat (40) @(negedge clk);
        checkOutput(1'b0);

        $display("[TB] step_count wrap");
        pulses4 = 0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk) btn4 = 1'b1;
            repeat (8) @(negedge clk);
            btn4 = 1'b0;
            repeat (10) @(negedge clk);
            if (i == 16) checkValue("wrap_16", 32'(step_count4), 32'd0);
        end
        checkValue("wrap_17", 32'(step_count4), 32'd1);
        checkValue("wrap_pulses", 32'(pulses4), 32'd17);
        checkValue("wrap_running", 32'(running4), 32'd0);
        checkValue("wrap_bp_hit", 32'(bp_hit4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
